// File: rtl/mem_port_arbiter.sv
// ---------------------------------------------------------------------------
// mem_port_arbiter
//
// Shares one downstream single-port memory between the instruction-fetch
// port (i_*) and the data/LSU port (d_*) of the core.
//
// Arbitration is round-robin between the two requesters. Once a beat has been
// presented downstream and stalled (m_valid & !m_ready), the grant is locked
// to that owner until the downstream port accepts it. Every accepted beat,
// read or write, produces exactly one rvalid one cycle later, routed to the
// requester that issued it. A saturating counter records cycles in which
// both requesters wanted the port, the port was ready, and one was refused.
//
// Ports
//   clk, rst        clock, synchronous active-high reset
//   i_valid/i_ready instruction request / grant
//   i_addr          instruction address
//   i_rdata         instruction read data (broadcast of m_rdata)
//   i_rvalid        instruction response valid
//   d_valid/d_ready data request / grant
//   d_addr          data address
//   d_write_en      data write strobe
//   d_byte_en       data byte enables
//   d_wdata         data write data
//   d_rdata         data read data (broadcast of m_rdata)
//   d_rvalid        data response valid
//   m_valid/m_ready downstream request / accept
//   m_addr          downstream address
//   m_write_en      downstream write strobe
//   m_byte_en       downstream byte enables
//   m_wdata         downstream write data
//   m_rdata         downstream read data, valid the cycle after accept
//   contention_cnt  saturating count of refused-while-contending cycles
//   clr_cnt         synchronous clear of contention_cnt (wins over increment)
// ---------------------------------------------------------------------------
module mem_port_arbiter #(
  parameter int ABITS    = 32,
  parameter int DBITS    = 32,
  parameter int CNT_BITS = 16
) (
  input  logic                  clk,
  input  logic                  rst,

  input  logic                  i_valid,
  output logic                  i_ready,
  input  logic [ABITS-1:0]      i_addr,
  output logic [DBITS-1:0]      i_rdata,
  output logic                  i_rvalid,

  input  logic                  d_valid,
  output logic                  d_ready,
  input  logic [ABITS-1:0]      d_addr,
  input  logic                  d_write_en,
  input  logic [DBITS/8-1:0]    d_byte_en,
  input  logic [DBITS-1:0]      d_wdata,
  output logic [DBITS-1:0]      d_rdata,
  output logic                  d_rvalid,

  output logic                  m_valid,
  input  logic                  m_ready,
  output logic [ABITS-1:0]      m_addr,
  output logic                  m_write_en,
  output logic [DBITS/8-1:0]    m_byte_en,
  output logic [DBITS-1:0]      m_wdata,
  input  logic [DBITS-1:0]      m_rdata,

  output logic [CNT_BITS-1:0]   contention_cnt,
  input  logic                  clr_cnt
);

  localparam int BE_BITS = DBITS / 8;

  localparam logic [CNT_BITS-1:0] CNT_ONE = {{(CNT_BITS-1){1'b0}}, 1'b1};
  localparam logic [CNT_BITS-1:0] CNT_MAX = {CNT_BITS{1'b1}};

  typedef enum logic {
    ST_FREE   = 1'b0,
    ST_LOCKED = 1'b1
  } state_e;

  typedef enum logic {
    OWN_INSTR = 1'b0,
    OWN_DATA  = 1'b1
  } owner_e;

  // -------------------------------------------------------------------------
  // State
  // -------------------------------------------------------------------------
  state_e               state_q,      state_d;
  owner_e               lock_owner_q, lock_owner_d;
  owner_e               last_owner_q, last_owner_d;
  owner_e               resp_owner_q, resp_owner_d;
  logic                 resp_pend_q,  resp_pend_d;
  logic [CNT_BITS-1:0]  cnt_q,        cnt_d;

  // -------------------------------------------------------------------------
  // Owner selection
  // -------------------------------------------------------------------------
  owner_e sel_owner;
  logic   sel_instr;
  logic   sel_data;
  logic   handshake;
  logic   conflict;

  always_comb begin
    sel_owner = OWN_INSTR;
    if (state_q == ST_LOCKED) begin
      // A stalled beat must be re-presented unchanged, so the owner is frozen
      // even if the other requester has become valid meanwhile.
      sel_owner = lock_owner_q;
    end else if (i_valid && d_valid) begin
      // Round-robin: whoever was not served last wins the tie.
      if (last_owner_q == OWN_INSTR) begin
        sel_owner = OWN_DATA;
      end else begin
        sel_owner = OWN_INSTR;
      end
    end else if (d_valid) begin
      sel_owner = OWN_DATA;
    end else begin
      sel_owner = OWN_INSTR;
    end
  end

  assign sel_instr = (sel_owner == OWN_INSTR);
  assign sel_data  = (sel_owner == OWN_DATA);

  // -------------------------------------------------------------------------
  // Handshake routing (combinational)
  // -------------------------------------------------------------------------
  assign m_valid = i_valid | d_valid;
  assign i_ready = m_ready & sel_instr & i_valid;
  assign d_ready = m_ready & sel_data  & d_valid;

  // A beat transfers exactly when the selected requester is granted.
  assign handshake = i_ready | d_ready;

  // Both wanted the port, the port could take a beat, and someone lost.
  assign conflict = i_valid & d_valid & m_ready & (~i_ready | ~d_ready);

  // -------------------------------------------------------------------------
  // Downstream payload mux. Instruction beats are always full-width reads.
  // -------------------------------------------------------------------------
  assign m_addr     = sel_data ? d_addr  : i_addr;
  assign m_write_en = sel_data & d_write_en;
  assign m_wdata    = sel_data ? d_wdata : '0;

  for (genvar gi = 0; gi < BE_BITS; gi++) begin : g_byte_en
    assign m_byte_en[gi] = sel_data ? d_byte_en[gi] : 1'b1;
  end

  // -------------------------------------------------------------------------
  // Response path: read data is broadcast, rvalid is steered by owner.
  // -------------------------------------------------------------------------
  assign i_rdata  = m_rdata;
  assign d_rdata  = m_rdata;
  assign i_rvalid = resp_pend_q & (resp_owner_q == OWN_INSTR);
  assign d_rvalid = resp_pend_q & (resp_owner_q == OWN_DATA);

  assign contention_cnt = cnt_q;

  // -------------------------------------------------------------------------
  // Next-state logic
  // -------------------------------------------------------------------------
  always_comb begin
    state_d      = state_q;
    lock_owner_d = lock_owner_q;
    last_owner_d = last_owner_q;
    resp_owner_d = resp_owner_q;
    resp_pend_d  = handshake;
    cnt_d        = cnt_q;

    case (state_q)
      ST_FREE: begin
        if (m_valid && !m_ready) begin
          state_d      = ST_LOCKED;
          lock_owner_d = sel_owner;
        end
      end
      ST_LOCKED: begin
        if (m_ready) begin
          state_d = ST_FREE;
        end
      end
      default: begin
        state_d = ST_FREE;
      end
    endcase

    // Fairness history moves only when a beat actually completes, so a
    // stalled grant does not cost the owner its turn.
    if (handshake) begin
      last_owner_d = sel_owner;
      resp_owner_d = sel_owner;
    end

    if (clr_cnt) begin
      cnt_d = '0;
    end else if (conflict && (cnt_q != CNT_MAX)) begin
      cnt_d = cnt_q + CNT_ONE;
    end
  end

  // -------------------------------------------------------------------------
  // Registers
  // -------------------------------------------------------------------------
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q      <= ST_FREE;
      lock_owner_q <= OWN_INSTR;
      last_owner_q <= OWN_INSTR;
      resp_owner_q <= OWN_INSTR;
      resp_pend_q  <= 1'b0;
      cnt_q        <= '0;
    end else begin
      state_q      <= state_d;
      lock_owner_q <= lock_owner_d;
      last_owner_q <= last_owner_d;
      resp_owner_q <= resp_owner_d;
      resp_pend_q  <= resp_pend_d;
      cnt_q        <= cnt_d;
    end
  end

endmodule

// File: tb/tb_mem_port_arbiter.sv
// ---------------------------------------------------------------------------
// tb_mem_port_arbiter
//
// Directed table of per-cycle vectors (inputs + hand-computed outputs),
// followed by hand-written sequences for counter saturation/clear, reset in
// the middle of traffic, and a randomised alternating-requester run with a
// scoreboard for response routing.
// ---------------------------------------------------------------------------
module tb_mem_port_arbiter;

  localparam int ABITS = 32;
  localparam int DBITS = 32;
  localparam int CNT_BITS = 4;

  logic              clk;
  logic              rst;
  logic              i_valid, i_ready, i_rvalid;
  logic [ABITS-1:0]  i_addr;
  logic [DBITS-1:0]  i_rdata;
  logic              d_valid, d_ready, d_rvalid, d_write_en;
  logic [ABITS-1:0]  d_addr;
  logic [3:0]        d_byte_en;
  logic [DBITS-1:0]  d_wdata, d_rdata;
  logic              m_valid, m_ready, m_write_en;
  logic [ABITS-1:0]  m_addr;
  logic [3:0]        m_byte_en;
  logic [DBITS-1:0]  m_wdata, m_rdata;
  logic [CNT_BITS-1:0] contention_cnt;
  logic              clr_cnt;

  mem_port_arbiter #(
    .ABITS(ABITS),
    .DBITS(DBITS),
    .CNT_BITS(CNT_BITS)
  ) dut (
    .clk(clk),
    .rst(rst),
    .i_valid(i_valid),
    .i_ready(i_ready),
    .i_addr(i_addr),
    .i_rdata(i_rdata),
    .i_rvalid(i_rvalid),
    .d_valid(d_valid),
    .d_ready(d_ready),
    .d_addr(d_addr),
    .d_write_en(d_write_en),
    .d_byte_en(d_byte_en),
    .d_wdata(d_wdata),
    .d_rdata(d_rdata),
    .d_rvalid(d_rvalid),
    .m_valid(m_valid),
    .m_ready(m_ready),
    .m_addr(m_addr),
    .m_write_en(m_write_en),
    .m_byte_en(m_byte_en),
    .m_wdata(m_wdata),
    .m_rdata(m_rdata),
    .contention_cnt(contention_cnt),
    .clr_cnt(clr_cnt)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  int passed = 0;
  int total  = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act === exp) begin
      passed++;
    end else begin
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  typedef struct {
    logic        rst, iv, dv, dwe, mr, clr;
    logic [31:0] ia, da, dwd;
    logic [3:0]  dbe;
    logic        e_ir, e_dr, e_mv, e_mwe, e_irv, e_drv;
    logic [31:0] e_ma, e_mwd;
    logic [3:0]  e_mbe, e_cnt;
  } vec_t;

  function automatic vec_t mk(
    input logic r, input logic iv, input logic [31:0] ia,
    input logic dv, input logic [31:0] da, input logic dwe,
    input logic [3:0] dbe, input logic [31:0] dwd, input logic mr, input logic clr,
    input logic e_ir, input logic e_dr, input logic e_mv, input logic [31:0] e_ma,
    input logic e_mwe, input logic [3:0] e_mbe, input logic [31:0] e_mwd,
    input logic e_irv, input logic e_drv, input logic [3:0] e_cnt);
    vec_t v;
    v.rst = r;  v.iv = iv;  v.ia = ia;  v.dv = dv;  v.da = da;  v.dwe = dwe;
    v.dbe = dbe; v.dwd = dwd; v.mr = mr; v.clr = clr;
    v.e_ir = e_ir; v.e_dr = e_dr; v.e_mv = e_mv; v.e_ma = e_ma; v.e_mwe = e_mwe;
    v.e_mbe = e_mbe; v.e_mwd = e_mwd; v.e_irv = e_irv; v.e_drv = e_drv; v.e_cnt = e_cnt;
    return v;
  endfunction

  task automatic drive(input logic r, input logic iv, input logic [31:0] ia,
                       input logic dv, input logic [31:0] da, input logic dwe,
                       input logic [3:0] dbe, input logic [31:0] dwd,
                       input logic mr, input logic clr, input logic [31:0] rd);
    rst = r; i_valid = iv; i_addr = ia; d_valid = dv; d_addr = da;
    d_write_en = dwe; d_byte_en = dbe; d_wdata = dwd; m_ready = mr;
    clr_cnt = clr; m_rdata = rd;
  endtask

  // Inputs change at the falling edge; outputs are sampled 1 time unit later,
  // well before the next rising edge.
  task automatic apply(input vec_t v, input int idx);
    logic [31:0] rd;
    rd = 32'hA500_0000 + 32'(idx);
    @(negedge clk);
    drive(v.rst, v.iv, v.ia, v.dv, v.da, v.dwe, v.dbe, v.dwd, v.mr, v.clr, rd);
    #1;
    chk($sformatf("v%0d i_ready", idx),  32'(i_ready),  32'(v.e_ir));
    chk($sformatf("v%0d d_ready", idx),  32'(d_ready),  32'(v.e_dr));
    chk($sformatf("v%0d m_valid", idx),  32'(m_valid),  32'(v.e_mv));
    chk($sformatf("v%0d i_rvalid", idx), 32'(i_rvalid), 32'(v.e_irv));
    chk($sformatf("v%0d d_rvalid", idx), 32'(d_rvalid), 32'(v.e_drv));
    chk($sformatf("v%0d cnt", idx),      32'(contention_cnt), 32'(v.e_cnt));
    chk($sformatf("v%0d i_rdata", idx),  i_rdata, rd);
    chk($sformatf("v%0d d_rdata", idx),  d_rdata, rd);
    if (v.e_mv) begin
      chk($sformatf("v%0d m_addr", idx),     m_addr, v.e_ma);
      chk($sformatf("v%0d m_write_en", idx), 32'(m_write_en), 32'(v.e_mwe));
      chk($sformatf("v%0d m_byte_en", idx),  32'(m_byte_en), 32'(v.e_mbe));
      chk($sformatf("v%0d m_wdata", idx),    m_wdata, v.e_mwd);
    end
  endtask

  vec_t tbl1[$];
  vec_t tbl2[$];
  int   vidx = 0;

  // Random-phase scoreboard state
  int          cur_owner;
  logic        exp_irv, exp_drv;
  int          hs_cnt, rv_cnt;
  logic [31:0] r_ia, r_da, r_dwd;
  logic        r_dwe, r_mr;
  logic [3:0]  r_dbe;

  initial begin
    // Idle cycle with downstream ready; rvalids come from the previous cycle.
    //               rst iv ia            dv da     we be    wdata         mr clr | ir dr mv ma            we be    wdata         irv drv cnt
    tbl1.push_back(mk(0, 0, 32'h0,        0, 32'h0,  0, 4'h0, 32'h0,        1, 0,   0, 0, 0, 32'h0,        0, 4'h0, 32'h0,        0, 0, 4'd0));
    // Instruction-only fetches
    tbl1.push_back(mk(0, 1, 32'h10000000, 0, 32'h0,  0, 4'h0, 32'h0,        1, 0,   1, 0, 1, 32'h10000000, 0, 4'hF, 32'h0,        0, 0, 4'd0));
    tbl1.push_back(mk(0, 1, 32'h10000004, 0, 32'h0,  0, 4'h0, 32'h0,        1, 0,   1, 0, 1, 32'h10000004, 0, 4'hF, 32'h0,        1, 0, 4'd0));
    tbl1.push_back(mk(0, 0, 32'h0,        0, 32'h0,  0, 4'h0, 32'h0,        1, 0,   0, 0, 0, 32'h0,        0, 4'h0, 32'h0,        1, 0, 4'd0));
    tbl1.push_back(mk(0, 0, 32'h0,        0, 32'h0,  0, 4'h0, 32'h0,        1, 0,   0, 0, 0, 32'h0,        0, 4'h0, 32'h0,        0, 0, 4'd0));
    // Both valid for 4 cycles: DATA, INSTR, DATA, INSTR
    tbl1.push_back(mk(0, 1, 32'h100,      1, 32'h200, 0, 4'hF, 32'h11111111, 1, 0,  0, 1, 1, 32'h200,      0, 4'hF, 32'h11111111, 0, 0, 4'd0));
    tbl1.push_back(mk(0, 1, 32'h100,      1, 32'h200, 0, 4'hF, 32'h11111111, 1, 0,  1, 0, 1, 32'h100,      0, 4'hF, 32'h0,        0, 1, 4'd1));
    tbl1.push_back(mk(0, 1, 32'h100,      1, 32'h200, 0, 4'hF, 32'h11111111, 1, 0,  0, 1, 1, 32'h200,      0, 4'hF, 32'h11111111, 1, 0, 4'd2));
    tbl1.push_back(mk(0, 1, 32'h100,      1, 32'h200, 0, 4'hF, 32'h11111111, 1, 0,  1, 0, 1, 32'h100,      0, 4'hF, 32'h0,        0, 1, 4'd3));
    // Data-only read so that INSTR would win a free tie next
    tbl1.push_back(mk(0, 0, 32'h0,        1, 32'h40,  0, 4'hF, 32'h0,        1, 0,  0, 1, 1, 32'h40,       0, 4'hF, 32'h0,        1, 0, 4'd4));
    // Stalled write locks DATA; instruction appears mid-stall
    tbl1.push_back(mk(0, 0, 32'h0,        1, 32'h20,  1, 4'h3, 32'hDEADBEEF, 0, 0,  0, 0, 1, 32'h20,       1, 4'h3, 32'hDEADBEEF, 0, 1, 4'd4));
    tbl1.push_back(mk(0, 1, 32'h300,      1, 32'h20,  1, 4'h3, 32'hDEADBEEF, 0, 0,  0, 0, 1, 32'h20,       1, 4'h3, 32'hDEADBEEF, 0, 0, 4'd4));
    tbl1.push_back(mk(0, 1, 32'h300,      1, 32'h20,  1, 4'h3, 32'hDEADBEEF, 0, 0,  0, 0, 1, 32'h20,       1, 4'h3, 32'hDEADBEEF, 0, 0, 4'd4));
    tbl1.push_back(mk(0, 1, 32'h300,      1, 32'h20,  1, 4'h3, 32'hDEADBEEF, 1, 0,  0, 1, 1, 32'h20,       1, 4'h3, 32'hDEADBEEF, 0, 0, 4'd4));
    tbl1.push_back(mk(0, 1, 32'h300,      0, 32'h0,   0, 4'h0, 32'h0,        1, 0,  1, 0, 1, 32'h300,      0, 4'hF, 32'h0,        0, 1, 4'd5));
    tbl1.push_back(mk(0, 0, 32'h0,        0, 32'h0,   0, 4'h0, 32'h0,        1, 0,  0, 0, 0, 32'h0,        0, 4'h0, 32'h0,        1, 0, 4'd5));
    // Clear while idle
    tbl1.push_back(mk(0, 0, 32'h0,        0, 32'h0,   0, 4'h0, 32'h0,        1, 1,  0, 0, 0, 32'h0,        0, 4'h0, 32'h0,        0, 0, 4'd5));
    tbl1.push_back(mk(0, 0, 32'h0,        0, 32'h0,   0, 4'h0, 32'h0,        1, 0,  0, 0, 0, 32'h0,        0, 4'h0, 32'h0,        0, 0, 4'd0));

    // Reset in the middle of traffic
    tbl2.push_back(mk(0, 0, 32'h0,        1, 32'h50,  0, 4'hF, 32'h0,        1, 0,  0, 1, 1, 32'h50,       0, 4'hF, 32'h0,        0, 0, 4'd1));
    tbl2.push_back(mk(0, 1, 32'h60,       0, 32'h0,   0, 4'h0, 32'h0,        0, 0,  0, 0, 1, 32'h60,       0, 4'hF, 32'h0,        0, 1, 4'd1));
    tbl2.push_back(mk(1, 1, 32'h60,       1, 32'h70,  0, 4'hF, 32'h0,        0, 0,  0, 0, 1, 32'h60,       0, 4'hF, 32'h0,        0, 0, 4'd1));
    tbl2.push_back(mk(0, 1, 32'h60,       1, 32'h70,  0, 4'hF, 32'h0,        1, 0,  0, 1, 1, 32'h70,       0, 4'hF, 32'h0,        0, 0, 4'd0));
    tbl2.push_back(mk(1, 1, 32'h60,       0, 32'h0,   0, 4'h0, 32'h0,        1, 0,  1, 0, 1, 32'h60,       0, 4'hF, 32'h0,        0, 1, 4'd1));
    tbl2.push_back(mk(0, 0, 32'h0,        0, 32'h0,   0, 4'h0, 32'h0,        1, 0,  0, 0, 0, 32'h0,        0, 4'h0, 32'h0,        0, 0, 4'd0));

    // Power-on reset
    drive(1, 0, 0, 0, 0, 0, 0, 0, 1, 0, 0);
    repeat (2) @(posedge clk);

    foreach (tbl1[k]) begin
      apply(tbl1[k], vidx);
      vidx++;
    end

    // Saturation: 17 conflicts on a 4-bit counter must stop at 15.
    for (int k = 0; k < 17; k++) begin
      @(negedge clk);
      drive(0, 1, 32'h80, 1, 32'h90, 0, 4'hF, 32'h0, 1, 0, 32'h0);
      #1;
      chk($sformatf("sat%0d cnt", k), 32'(contention_cnt), (k > 15) ? 32'd15 : 32'(k));
      chk($sformatf("sat%0d one_grant", k), 32'(i_ready ^ d_ready), 32'd1);
    end
    // Clear in the same cycle as a conflict wins over the increment.
    @(negedge clk);
    drive(0, 1, 32'h80, 1, 32'h90, 0, 4'hF, 32'h0, 1, 1, 32'h0);
    #1;
    chk("sat_hold cnt", 32'(contention_cnt), 32'd15);
    @(negedge clk);
    drive(0, 1, 32'h80, 1, 32'h90, 0, 4'hF, 32'h0, 1, 0, 32'h0);
    #1;
    chk("clr cnt", 32'(contention_cnt), 32'd0);
    @(negedge clk);
    drive(0, 0, 0, 0, 0, 0, 0, 0, 1, 0, 0);
    #1;
    chk("post_clr cnt", 32'(contention_cnt), 32'd1);
    @(negedge clk);
    drive(0, 0, 0, 0, 0, 0, 0, 0, 1, 0, 0);

    foreach (tbl2[k]) begin
      apply(tbl2[k], vidx);
      vidx++;
    end

    // Alternating single requesters, random downstream stalls.
    cur_owner = 0;
    exp_irv = 1'b0;
    exp_drv = 1'b0;
    hs_cnt = 0;
    rv_cnt = 0;
    r_ia = $urandom; r_da = $urandom; r_dwd = $urandom;
    r_dwe = 1'($urandom_range(0, 1)); r_dbe = 4'($urandom_range(0, 15));
    for (int k = 0; k < 1000; k++) begin
      @(negedge clk);
      r_mr = 1'($urandom_range(0, 1));
      drive(0, cur_owner == 0, r_ia, cur_owner == 1, r_da, r_dwe, r_dbe, r_dwd,
            r_mr, 0, $urandom);
      #1;
      chk($sformatf("rnd%0d i_rvalid", k), 32'(i_rvalid), 32'(exp_irv));
      chk($sformatf("rnd%0d d_rvalid", k), 32'(d_rvalid), 32'(exp_drv));
      chk($sformatf("rnd%0d i_ready", k), 32'(i_ready), 32'(r_mr && cur_owner == 0));
      chk($sformatf("rnd%0d d_ready", k), 32'(d_ready), 32'(r_mr && cur_owner == 1));
      chk($sformatf("rnd%0d m_addr", k), m_addr, (cur_owner == 0) ? r_ia : r_da);
      rv_cnt += int'(i_rvalid) + int'(d_rvalid);
      exp_irv = r_mr && cur_owner == 0;
      exp_drv = r_mr && cur_owner == 1;
      if (r_mr) begin
        hs_cnt++;
        cur_owner = 1 - cur_owner;
        r_ia = $urandom; r_da = $urandom; r_dwd = $urandom;
        r_dwe = 1'($urandom_range(0, 1)); r_dbe = 4'($urandom_range(0, 15));
      end
    end
    @(negedge clk);
    drive(0, 0, 0, 0, 0, 0, 0, 0, 1, 0, 0);
    #1;
    chk("rnd_last i_rvalid", 32'(i_rvalid), 32'(exp_irv));
    chk("rnd_last d_rvalid", 32'(d_rvalid), 32'(exp_drv));
    rv_cnt += int'(i_rvalid) + int'(d_rvalid);
    chk("rnd rvalid_count", 32'(rv_cnt), 32'(hs_cnt));

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
